// File: rtl/calc_pkg.sv
// Shared state, key and operator encodings for the keypad calculator sequencer.
package calc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OPA    = 3'd1,
      ST_OPER   = 3'd2,
      ST_OPB    = 3'd3,
      ST_EXEC   = 3'd4,
      ST_RESULT = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_EQ  = 4'hD;
   localparam logic [3:0] KEY_CLR = 4'hE;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   function automatic logic is_oper(input logic [3:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
   endfunction

   function automatic logic [1:0] key_to_oper(input logic [3:0] k);
      return 2'(k - KEY_ADD);
   endfunction

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/calc_mul.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles from start to done.
module calc_mul #(
   parameter int unsigned WIDTH     = 10,
   parameter int unsigned RES_WIDTH = 2 * WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_done,
   output logic [RES_WIDTH-1:0] o_product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [RES_WIDTH-1:0] r_acc;
   logic [RES_WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [CW-1:0]        r_cnt;
   logic                 r_busy;
   logic                 r_done;

   // The start cycle already folds in bit 0, so WIDTH-1 further steps remain.
   always_ff @(posedge clk) begin
      if (reset || i_abort) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_acc    <= i_b[0] ? RES_WIDTH'(i_a) : '0;
            r_mcand  <= RES_WIDTH'(i_a) << 1;
            r_mplier <= i_b >> 1;
            r_cnt    <= CW'(WIDTH - 1);
            r_busy   <= 1'b1;
         end else if (r_busy) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done    = r_done;
   assign o_product = r_acc;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds decimal operands from key events, runs add/sub/mul, drives display and status.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS    = 3,
   parameter int unsigned WIDTH     = 10,
   parameter int unsigned RES_WIDTH = 2 * WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_key_valid,
   input  logic [3:0]           i_key_code,
   output logic [RES_WIDTH-1:0] o_display_value,
   output logic                 o_display_neg,
   output logic [WIDTH-1:0]     o_op_a,
   output logic [WIDTH-1:0]     o_op_b,
   output logic [1:0]           o_operator,
   output logic [2:0]           o_state,
   output logic                 o_busy,
   output logic                 o_result_valid,
   output logic                 o_error
);

   localparam int unsigned CW    = $clog2(DIGITS + 1);
   localparam int unsigned EW    = WIDTH + 4;
   localparam int unsigned LIMIT = pow10(DIGITS);

   state_t               r_state, w_state_n;
   logic [WIDTH-1:0]     r_entry, w_entry_n;
   logic [CW-1:0]        r_count, w_count_n;
   logic [WIDTH-1:0]     r_op_a, w_op_a_n;
   logic [WIDTH-1:0]     r_op_b, w_op_b_n;
   logic [1:0]           r_oper, w_oper_n;
   logic [RES_WIDTH-1:0] r_result, w_result_n;
   logic                 r_neg, w_neg_n;
   logic [RES_WIDTH-1:0] r_display, w_display_n;
   logic                 r_disp_neg, w_disp_neg_n;
   logic                 r_busy, r_rv, r_err;

   logic                 w_digit, w_op, w_eq, w_clr, w_room;
   logic [EW-1:0]        w_entry_calc;
   logic [WIDTH-1:0]     w_entry_acc, w_digit_val;
   logic [RES_WIDTH-1:0] w_addsub;
   logic                 w_sub_neg;
   logic                 w_mul_start, w_mul_done;
   logic [RES_WIDTH-1:0] w_product;

   assign w_digit      = i_key_valid && is_digit(i_key_code);
   assign w_op         = i_key_valid && is_oper(i_key_code);
   assign w_eq         = i_key_valid && (i_key_code == KEY_EQ);
   assign w_clr        = i_key_valid && (i_key_code == KEY_CLR);
   assign w_room       = r_count < CW'(DIGITS);
   assign w_entry_calc = EW'(r_entry) * EW'(10) + EW'(i_key_code);
   assign w_entry_acc  = WIDTH'(w_entry_calc);
   assign w_digit_val  = WIDTH'(i_key_code);
   assign w_sub_neg    = (r_oper == OP_SUB) && (r_op_a < r_op_b);
   assign w_mul_start  = (r_state == ST_OPB) && w_eq && (r_oper == OP_MUL);

   always_comb begin
      if (r_oper == OP_SUB)
         w_addsub = w_sub_neg ? RES_WIDTH'(r_op_b - r_op_a) : RES_WIDTH'(r_op_a - r_op_b);
      else
         w_addsub = RES_WIDTH'(r_op_a) + RES_WIDTH'(r_op_b);
   end

   calc_mul #(
      .WIDTH     (WIDTH),
      .RES_WIDTH (RES_WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_abort   (w_clr),
      .i_a       (r_op_a),
      .i_b       (r_entry),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_entry    <= '0;
         r_count    <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_oper     <= OP_ADD;
         r_result   <= '0;
         r_neg      <= 1'b0;
         r_display  <= '0;
         r_disp_neg <= 1'b0;
         r_busy     <= 1'b0;
         r_rv       <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_entry    <= w_entry_n;
         r_count    <= w_count_n;
         r_op_a     <= w_op_a_n;
         r_op_b     <= w_op_b_n;
         r_oper     <= w_oper_n;
         r_result   <= w_result_n;
         r_neg      <= w_neg_n;
         r_display  <= w_display_n;
         r_disp_neg <= w_disp_neg_n;
         r_busy     <= (w_state_n == ST_EXEC);
         r_rv       <= (w_state_n == ST_RESULT);
         r_err      <= (w_state_n == ST_ERROR);
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_entry_n  = r_entry;
      w_count_n  = r_count;
      w_op_a_n   = r_op_a;
      w_op_b_n   = r_op_b;
      w_oper_n   = r_oper;
      w_result_n = r_result;
      w_neg_n    = r_neg;

      unique case (r_state)
         ST_IDLE: begin
            if (w_digit) begin
               w_state_n = ST_OPA;
               w_entry_n = w_digit_val;
               w_count_n = CW'(1);
            end else if (w_op) begin
               w_state_n = ST_OPER;
               w_op_a_n  = '0;
               w_oper_n  = key_to_oper(i_key_code);
            end
         end
         ST_OPA: begin
            if (w_digit && w_room) begin
               w_entry_n = w_entry_acc;
               w_count_n = r_count + CW'(1);
            end else if (w_op) begin
               w_state_n = ST_OPER;
               w_op_a_n  = r_entry;
               w_oper_n  = key_to_oper(i_key_code);
               w_entry_n = '0;
               w_count_n = '0;
            end
         end
         ST_OPER: begin
            if (w_op) begin
               w_oper_n = key_to_oper(i_key_code);
            end else if (w_digit) begin
               w_state_n = ST_OPB;
               w_entry_n = w_digit_val;
               w_count_n = CW'(1);
            end
         end
         ST_OPB: begin
            if (w_digit && w_room) begin
               w_entry_n = w_entry_acc;
               w_count_n = r_count + CW'(1);
            end else if (w_eq) begin
               w_state_n  = ST_EXEC;
               w_op_b_n   = r_entry;
               w_entry_n  = '0;
               w_count_n  = '0;
               w_result_n = '0;
               w_neg_n    = 1'b0;
            end
         end
         ST_EXEC: begin
            if (r_oper != OP_MUL) begin
               w_state_n  = ST_RESULT;
               w_result_n = w_addsub;
               w_neg_n    = w_sub_neg;
            end else if (w_mul_done) begin
               w_state_n  = ST_RESULT;
               w_result_n = w_product;
            end
         end
         ST_RESULT: begin
            if (w_digit) begin
               w_state_n  = ST_OPA;
               w_entry_n  = w_digit_val;
               w_count_n  = CW'(1);
               w_result_n = '0;
               w_neg_n    = 1'b0;
            end else if (w_op) begin
               // Only a non-negative result that fits an operand can chain.
               if (!r_neg && (r_result < RES_WIDTH'(LIMIT))) begin
                  w_state_n = ST_OPER;
                  w_op_a_n  = WIDTH'(r_result);
                  w_oper_n  = key_to_oper(i_key_code);
               end else begin
                  w_state_n = ST_ERROR;
               end
            end
         end
         ST_ERROR: begin
         end
         default: w_state_n = ST_IDLE;
      endcase

      if (w_clr) begin
         w_state_n  = ST_IDLE;
         w_entry_n  = '0;
         w_count_n  = '0;
         w_op_a_n   = '0;
         w_op_b_n   = '0;
         w_oper_n   = OP_ADD;
         w_result_n = '0;
         w_neg_n    = 1'b0;
      end

      w_display_n  = '0;
      w_disp_neg_n = 1'b0;
      unique case (w_state_n)
         ST_OPA, ST_OPB:    w_display_n = RES_WIDTH'(w_entry_n);
         ST_OPER:           w_display_n = RES_WIDTH'(w_op_a_n);
         ST_EXEC, ST_RESULT: begin
            w_display_n  = w_result_n;
            w_disp_neg_n = w_neg_n;
         end
         default: w_display_n = '0;
      endcase
   end

   assign o_display_value = r_display;
   assign o_display_neg   = r_disp_neg;
   assign o_op_a          = r_op_a;
   assign o_op_b          = r_op_b;
   assign o_operator      = r_oper;
   assign o_state         = r_state;
   assign o_busy          = r_busy;
   assign o_result_valid  = r_rv;
   assign o_error         = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed key sequences plus random keys against a behavioural calculator model.
module tb_calc_sequencer;

   localparam int DIGITS    = 3;
   localparam int WIDTH     = 10;
   localparam int RES_WIDTH = 2 * WIDTH;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 key_valid = 1'b0;
   logic [3:0]           key_code = 4'h0;
   logic [RES_WIDTH-1:0] display_value;
   logic                 display_neg;
   logic [WIDTH-1:0]     op_a, op_b;
   logic [1:0]           oper;
   logic [2:0]           state;
   logic                 busy, result_valid, error;

   calc_sequencer #(.DIGITS(DIGITS), .WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_key_valid     (key_valid),
      .i_key_code      (key_code),
      .o_display_value (display_value),
      .o_display_neg   (display_neg),
      .o_op_a          (op_a),
      .o_op_b          (op_b),
      .o_operator      (oper),
      .o_state         (state),
      .o_busy          (busy),
      .o_result_valid  (result_valid),
      .o_error         (error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Calculator model: state numbers as published, arithmetic done directly, EXEC as a latency countdown.
   int     m_st = 0;
   longint m_entry = 0, m_cnt = 0, m_a = 0, m_b = 0, m_op = 0, m_res = 0;
   bit     m_neg = 1'b0;
   int     m_left = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_step(input bit rst, input bit kv, input logic [3:0] k);
      int d;
      bit dig, op, eq;
      d   = int'(k);
      dig = kv && (d <= 9);
      op  = kv && (d >= 10) && (d <= 12);
      eq  = kv && (d == 13);
      if (rst || (kv && d == 14)) begin
         m_st = 0; m_entry = 0; m_cnt = 0; m_a = 0; m_b = 0; m_op = 0;
         m_res = 0; m_neg = 1'b0; m_left = 0;
         return;
      end
      case (m_st)
         0: if (dig) begin m_st = 1; m_entry = d; m_cnt = 1; end
            else if (op) begin m_st = 2; m_a = 0; m_op = d - 10; end
         1: if (dig) begin
               if (m_cnt < DIGITS) begin m_entry = m_entry * 10 + d; m_cnt++; end
            end else if (op) begin
               m_st = 2; m_a = m_entry; m_op = d - 10; m_entry = 0; m_cnt = 0;
            end
         2: if (op) m_op = d - 10;
            else if (dig) begin m_st = 3; m_entry = d; m_cnt = 1; end
         3: if (dig) begin
               if (m_cnt < DIGITS) begin m_entry = m_entry * 10 + d; m_cnt++; end
            end else if (eq) begin
               m_st = 4; m_b = m_entry; m_entry = 0; m_cnt = 0; m_res = 0; m_neg = 1'b0;
               m_left = (m_op == 2) ? WIDTH : 1;
            end
         4: begin
            m_left--;
            if (m_left == 0) begin
               m_st = 5;
               case (m_op)
                  0: m_res = m_a + m_b;
                  1: begin m_neg = (m_a < m_b); m_res = m_neg ? m_b - m_a : m_a - m_b; end
                  default: m_res = m_a * m_b;
               endcase
            end
         end
         5: if (dig) begin
               m_st = 1; m_entry = d; m_cnt = 1; m_res = 0; m_neg = 1'b0;
            end else if (op) begin
               if (!m_neg && m_res < 10 ** DIGITS) begin m_st = 2; m_a = m_res; m_op = d - 10; end
               else m_st = 6;
            end
         default: ;
      endcase
   endfunction

   function automatic longint m_disp();
      case (m_st)
         1, 3:    return m_entry;
         2:       return m_a;
         4, 5:    return m_res;
         default: return 0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("display_value", 64'(display_value), 64'(m_disp()));
         check("display_neg", 64'(display_neg), 64'((m_st == 4 || m_st == 5) ? m_neg : 1'b0));
         check("op_a", 64'(op_a), 64'(m_a));
         check("op_b", 64'(op_b), 64'(m_b));
         check("operator", 64'(oper), 64'(m_op));
         check("state", 64'(state), 64'(m_st));
         check("busy", 64'(busy), 64'(m_st == 4));
         check("result_valid", 64'(result_valid), 64'(m_st == 5));
         check("error", 64'(error), 64'(m_st == 6));
      end
   end

   task automatic cycle(input bit kv, input logic [3:0] k, input bit rst);
      key_valid = kv;
      key_code  = k;
      reset     = rst;
      @(posedge clk);
      model_step(rst, kv, k);
      #1;
      key_valid = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 4'h0, 1'b0);
   endtask

   task automatic press_str(input string s);
      logic [3:0] k;
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] >= "0" && s[i] <= "9") k = 4'(s[i] - "0");
         else                            k = 4'(s[i] - "A" + 10);
         cycle(1'b1, k, 1'b0);
      end
   endtask

   task automatic wait_result(input int bound);
      int n;
      n = 0;
      while (!result_valid && n < bound) begin
         idle(1);
         n++;
      end
      check("result_wait", 64'(result_valid), 64'd1);
   endtask

   initial begin
      int busy_cycles;
      bit seen_rv;
      int r;
      logic [3:0] k;

      cycle(1'b0, 4'h0, 1'b1);
      cycle(1'b0, 4'h0, 1'b1);
      chk_en = 1'b1;
      check("rst_state", 64'(state), 64'd0);
      check("rst_display", 64'(display_value), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_op_a", 64'(op_a), 64'd0);

      // 12 + 34
      press_str("12A34D");
      check("add_busy_exec", 64'(busy), 64'd1);
      check("add_rv_early", 64'(result_valid), 64'd0);
      idle(1);
      check("add_rv", 64'(result_valid), 64'd1);
      check("add_value", 64'(display_value), 64'd46);
      check("add_model_pin", 64'(m_disp()), 64'd46);
      check("add_neg", 64'(display_neg), 64'd0);

      // 5 - 9
      press_str("E5B9D");
      wait_result(5);
      check("sub_value", 64'(display_value), 64'd4);
      check("sub_neg", 64'(display_neg), 64'd1);

      // 999 * 999
      press_str("E999C999D");
      busy_cycles = 0;
      while (busy && busy_cycles < 50) begin
         busy_cycles++;
         idle(1);
      end
      check("mul_busy_cycles", 64'(busy_cycles), 64'd10);
      check("mul_value", 64'(display_value), 64'd998001);
      check("mul_model_pin", 64'(m_res), 64'd998001);
      check("mul_rv", 64'(result_valid), 64'd1);

      // digit limit
      press_str("E1234");
      check("limit_value", 64'(display_value), 64'd123);
      check("limit_state", 64'(state), 64'd1);

      // chaining 2+3=5, then 5*4
      press_str("E2A3D");
      wait_result(5);
      press_str("C4D");
      wait_result(20);
      check("chain_value", 64'(display_value), 64'd20);
      check("chain_model_pin", 64'(m_res), 64'd20);

      // chaining an out-of-range result
      press_str("E999C2D");
      wait_result(20);
      check("big_value", 64'(display_value), 64'd1998);
      press_str("A");
      check("err_state", 64'(state), 64'd6);
      check("err_flag", 64'(error), 64'd1);
      check("err_display", 64'(display_value), 64'd0);
      press_str("E");
      check("clr_state", 64'(state), 64'd0);
      check("clr_display", 64'(display_value), 64'd0);
      check("clr_op_a", 64'(op_a), 64'd0);
      check("clr_op_b", 64'(op_b), 64'd0);
      check("clr_error", 64'(error), 64'd0);

      // clear on the 4th cycle of a multiply
      press_str("12C3D");
      idle(2);
      press_str("E");
      check("abort_state", 64'(state), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      seen_rv = 1'b0;
      repeat (15) begin
         idle(1);
         if (result_valid) seen_rv = 1'b1;
      end
      check("abort_no_rv", 64'(seen_rv), 64'd0);

      // reset mid-entry
      press_str("45");
      cycle(1'b0, 4'h0, 1'b1);
      check("rst_mid_state", 64'(state), 64'd0);
      check("rst_mid_display", 64'(display_value), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);

      // random key traffic
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 4) begin
            cycle(1'b0, 4'h0, 1'b1);
         end else if (r < 400) begin
            idle(1);
         end else begin
            r = $urandom_range(0, 99);
            if      (r < 50) k = 4'($urandom_range(0, 9));
            else if (r < 72) k = 4'($urandom_range(10, 12));
            else if (r < 90) k = 4'hD;
            else if (r < 93) k = 4'hE;
            else             k = 4'hF;
            cycle(1'b1, k, 1'b0);
         end
      end
      idle(12);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
